mem_arbiter: RTL and testbench

Single-port memory arbiter placed between the 5-stage pipelined MIPS datapath and one shared, unified instruction/data RAM. It serialises instruction fetches from IF and loads/stores from MEM onto the one RAM port through a fixed-latency access FSM. It also generates per-port stall signals, which the pipeline controller uses to drive the stage enables (`if_en`, `mem_en`, …). Data accesses have priority, and a streak counter prevents instruction-fetch starvation.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the single-port memory arbiter.
package mem_arb_pkg;

  // Width of the access-latency down-counter (LATENCY is 1..15).
  localparam int CNT_W = 4;

  // Access FSM state encoding.
  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_RESP   = 2'd2;

  // Owner of the transfer currently on the RAM port.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the pipelined MIPS core: serialises IF fetches
// and MEM loads/stores onto one RAM port with a fixed-latency access FSM.
// Data wins ties unless it has already won MAX_DATA_STREAK grants in a row.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | RAM port free; arbitrate between pending requests
// ARB_ACCESS | RAM enabled for LATENCY cycles, request fields frozen
// ARB_RESP   | owner's ack pulses for one cycle; requests ignored
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY         = 2,
  parameter int ADDR_WIDTH      = 10,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req,
  input  logic [31:0]           inst_addr,
  output logic [31:0]           inst_data,
  output logic                  inst_ack,
  output logic                  inst_stall,
  input  logic                  data_req,
  input  logic                  data_wen,
  input  logic [31:0]           data_addr,
  input  logic [31:0]           data_wdata,
  output logic [31:0]           data_rdata,
  output logic                  data_ack,
  output logic                  data_stall,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  localparam int SW = (MAX_DATA_STREAK < 2) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0]    STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    streak;
  logic             owner;
  logic             grant_any;
  logic             grant_data;

  // Byte-offset and out-of-range address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[31:ADDR_WIDTH+2], inst_addr[1:0],
                              data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

  // Stalls follow the request until its ack; forced low while in reset.
  assign inst_stall = inst_req & ~inst_ack & ~rst;
  assign data_stall = data_req & ~data_ack & ~rst;

  // Arbitration: data first, unless its streak has hit the limit and a fetch waits.
  always_comb begin
    grant_any  = inst_req | data_req;
    grant_data = data_req & (~inst_req | (streak != STREAK_MAX));
  end

  // Access FSM: grant in IDLE, count down the RAM latency, then pulse the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      owner      <= OWN_INST;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      inst_data  <= '0;
      data_rdata <= '0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_any) begin
            state     <= ARB_ACCESS;
            cnt       <= CNT_LOAD;
            ram_en    <= 1'b1;
            ram_wdata <= data_wdata;
            if (grant_data) begin
              owner    <= OWN_DATA;
              ram_we   <= data_wen;
              ram_addr <= data_addr[ADDR_WIDTH+1:2];
            end else begin
              owner    <= OWN_INST;
              ram_we   <= 1'b0;
              ram_addr <= inst_addr[ADDR_WIDTH+1:2];
            end
          end
        end
        ARB_ACCESS: begin
          if (cnt == CNT_ONE) begin
            state  <= ARB_RESP;
            cnt    <= '0;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
            if (owner == OWN_INST) begin
              inst_data <= ram_rdata;
              inst_ack  <= 1'b1;
            end else begin
              // A store has nothing to return; keep the last load result.
              if (!ram_we) data_rdata <= ram_rdata;
              data_ack <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ARB_RESP: begin
          state    <= ARB_IDLE;
          inst_ack <= 1'b0;
          data_ack <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Data-grant streak: saturating count of data wins, cleared by a fetch grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (state == ARB_IDLE && grant_any) begin
      if (!grant_data)                streak <= '0;
      else if (streak != STREAK_MAX)  streak <= streak + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;

  localparam int L  = 2;
  localparam int AW = 10;
  localparam int MS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0, data_wen = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
  logic [31:0] inst_data, data_rdata, ram_wdata, ram_rdata;
  logic        inst_ack, inst_stall, data_ack, data_stall, ram_en, ram_we;
  logic [AW-1:0] ram_addr;

  // Second instance with single-cycle latency, fetch-only traffic.
  logic        inst_req1 = 1'b0;
  logic [31:0] inst_addr1 = '0;
  logic        data_req1 = 1'b0, data_wen1 = 1'b0;
  logic [31:0] data_addr1 = '0, data_wdata1 = '0;
  logic [31:0] inst_data1, data_rdata1, ram_wdata1, ram_rdata1;
  logic        inst_ack1, inst_stall1, data_ack1, data_stall1, ram_en1, ram_we1;
  logic [AW-1:0] ram_addr1;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(L), .ADDR_WIDTH(AW), .MAX_DATA_STREAK(MS)) u_dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data),
    .inst_ack(inst_ack), .inst_stall(inst_stall),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
    .data_stall(data_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_arbiter #(.LATENCY(1), .ADDR_WIDTH(AW), .MAX_DATA_STREAK(MS)) u_dut1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req1), .inst_addr(inst_addr1), .inst_data(inst_data1),
    .inst_ack(inst_ack1), .inst_stall(inst_stall1),
    .data_req(data_req1), .data_wen(data_wen1), .data_addr(data_addr1),
    .data_wdata(data_wdata1), .data_rdata(data_rdata1), .data_ack(data_ack1),
    .data_stall(data_stall1),
    .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  // RAM environment for the main instance, and a fixed pattern for the second.
  logic [31:0] ram_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  assign ram_rdata  = ram_mem[ram_addr];
  assign ram_rdata1 = {22'd0, ram_addr1} ^ 32'hA5A5_0000;
  always @(posedge clk) if (ram_en && ram_we) ram_mem[ram_addr] = ram_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction schedule) ----------------
  // m_e counts clock edges since reset; a grant at edge g occupies the RAM for
  // the periods after edges g..g+L-1, acks after edge g+L, and the next grant
  // may happen no earlier than edge g+L+2.
  int          m_e = 0, m_g = 0, m_next = 0, m_streak = 0;
  bit          m_gv = 0, m_own_d = 0, m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = '0, m_idata = '0, m_drdata = '0;

  function automatic bit m_in_acc(input bit want_d);
    return m_gv && (m_own_d == want_d) && (m_e >= m_g) && (m_e < m_g + L);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_e = 0; m_g = 0; m_next = 0; m_streak = 0; m_gv = 0;
      m_idata = '0; m_drdata = '0;
    end else begin
      m_e++;
      if (m_gv && m_e == m_g + L) begin
        if (!m_own_d)   m_idata = ref_mem[m_addr];
        else if (!m_we) m_drdata = ref_mem[m_addr];
        else            ref_mem[m_addr] = m_wdata;
      end
      if (m_e >= m_next && (inst_req || data_req)) begin
        m_own_d = data_req && !(inst_req && m_streak == MS);
        if (m_own_d) begin
          m_we = data_wen;
          m_addr = data_addr[AW+1:2];
          if (m_streak < MS) m_streak++;
        end else begin
          m_we = 1'b0;
          m_addr = inst_addr[AW+1:2];
          m_streak = 0;
        end
        m_wdata = data_wdata;
        m_gv = 1;
        m_g = m_e;
        m_next = m_e + L + 2;
      end
    end
  end

  // Per-cycle comparison of the main instance against the model.
  always @(negedge clk) begin : cmp
    bit acc, ia, da;
    if (rst) begin
      chk1("rst_ram_en", ram_en, 1'b0);
      chk1("rst_ram_we", ram_we, 1'b0);
      chk1("rst_inst_ack", inst_ack, 1'b0);
      chk1("rst_data_ack", data_ack, 1'b0);
      chk1("rst_inst_stall", inst_stall, 1'b0);
      chk1("rst_data_stall", data_stall, 1'b0);
      chk32("rst_inst_data", inst_data, 32'd0);
      chk32("rst_data_rdata", data_rdata, 32'd0);
    end else begin
      acc = m_gv && m_e >= m_g && m_e < m_g + L;
      ia  = m_gv && m_e == m_g + L && !m_own_d;
      da  = m_gv && m_e == m_g + L && m_own_d;
      chk1("ram_en", ram_en, acc);
      chk1("ram_we", ram_we, acc && m_own_d && m_we);
      if (acc) begin
        chk32("ram_addr", 32'(ram_addr), 32'(m_addr));
        chk32("ram_wdata", ram_wdata, m_wdata);
      end
      chk1("inst_ack", inst_ack, ia);
      chk1("data_ack", data_ack, da);
      chk32("inst_data", inst_data, m_idata);
      chk32("data_rdata", data_rdata, m_drdata);
      chk1("inst_stall", inst_stall, inst_req && !ia);
      chk1("data_stall", data_stall, data_req && !da);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit want_d, output int cyc, output int en_n, output int we_n);
    cyc = 0; en_n = 0; we_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ram_en) en_n++;
      if (ram_we) we_n++;
      if (want_d ? data_ack : inst_ack) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_any(output bit is_d, output int cyc);
    cyc = 0; is_d = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (inst_ack || data_ack) begin
        is_d = data_ack;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_ram_en"}, ram_en, 1'b0);
    chk1({tag, "_ram_we"}, ram_we, 1'b0);
    chk32({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk32({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    chk32({tag, "_inst_data"}, inst_data, 32'd0);
    chk32({tag, "_data_rdata"}, data_rdata, 32'd0);
    chk1({tag, "_acks"}, inst_ack | data_ack, 1'b0);
    chk1({tag, "_stalls"}, inst_stall | data_stall, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[11:2] = 10'($urandom_range(0, 15));
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit          is_d, ia, da;
    int          cyc, en_n, we_n, acks, last, en1, n_ia, n_da, irun, drun, imax, dmax;
    logic [9:0]  seq;
    logic [31:0] exp1;

    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = $urandom;
      ref_mem[i] = ram_mem[i];
    end
    ram_mem[4] = 32'h2002_0005;
    ref_mem[4] = 32'h2002_0005;

    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Fetch only from byte 0x10 (word 4).
    inst_addr = 32'h0000_0010; inst_req = 1'b1;
    @(negedge clk);
    chk1("t1_stall_waiting", inst_stall, 1'b1);
    chk32("t1_addr", 32'(ram_addr), 32'd4);
    #1;
    wait_ack(1'b0, cyc, en_n, we_n);
    chk32("t1_ack_cycle", cyc, 32'd2);
    chk32("t1_en_cycles", en_n, 32'd1);
    chk32("t1_inst_data", inst_data, 32'h2002_0005);
    chk1("t1_stall_at_ack", inst_stall, 1'b0);
    #1 inst_req = 1'b0;
    repeat (2) tick();

    // Store 0xDEADBEEF to 0x20, then load it back as the next request.
    data_addr = 32'h0000_0020; data_wdata = 32'hDEAD_BEEF; data_wen = 1'b1; data_req = 1'b1;
    wait_ack(1'b1, cyc, en_n, we_n);
    chk32("t2_store_ack_cycle", cyc, 32'd3);
    chk32("t2_store_we_cycles", we_n, 32'd2);
    #1 data_wen = 1'b0; data_wdata = 32'h0;
    wait_ack(1'b1, cyc, en_n, we_n);
    chk32("t2_load_ack_cycle", cyc, 32'd4);
    chk32("t2_load_we_cycles", we_n, 32'd0);
    chk32("t2_load_data", data_rdata, 32'hDEAD_BEEF);
    #1 data_req = 1'b0;
    repeat (2) tick();

    // Simultaneous requests: data first, fetch right after.
    inst_addr = 32'h0000_0010; inst_req = 1'b1;
    data_addr = 32'h0000_0024; data_req = 1'b1;
    wait_ack(1'b1, cyc, en_n, we_n);
    chk32("t3_data_first", cyc, 32'd3);
    chk1("t3_inst_still_stalled", inst_stall, 1'b1);
    #1 data_req = 1'b0;
    wait_ack(1'b0, cyc, en_n, we_n);
    chk32("t3_inst_after_data", cyc, 32'd4);
    chk32("t3_inst_data", inst_data, 32'h2002_0005);
    #1 inst_req = 1'b0;
    repeat (2) tick();

    // Both held continuously: streak limit lets a fetch through every 5th grant.
    seq = '0;
    inst_req = 1'b1; data_req = 1'b1; data_wen = 1'b0; data_addr = 32'h0000_0028;
    for (int k = 0; k < 10; k++) begin
      wait_any(is_d, cyc);
      seq = {seq[8:0], is_d};
    end
    chk32("t4_grant_sequence", 32'(seq), 32'(10'b1111011110));
    #1 inst_req = 1'b0; data_req = 1'b0;
    repeat (2) tick();

    // Reset during the second ACCESS cycle of a load.
    data_addr = 32'h0000_0010; data_wen = 1'b0; data_req = 1'b1;
    @(negedge clk);
    chk1("t5_access1", ram_en, 1'b1);
    @(negedge clk);
    chk1("t5_access2", ram_en, 1'b1);
    #1 rst = 1'b1; data_req = 1'b0;
    #1 check_zero("t5_abort");
    tick();
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (data_ack) acks++;
    end
    chk32("t5_no_ack_after_abort", acks, 32'd0);
    #1 inst_addr = 32'h0000_0010; inst_req = 1'b1;
    wait_ack(1'b0, cyc, en_n, we_n);
    chk32("t5_fetch_cycle", cyc, 32'd3);
    chk32("t5_fetch_data", inst_data, 32'h2002_0005);
    #1 inst_req = 1'b0;
    repeat (2) tick();

    // Single-cycle latency instance: back-to-back fetches every 3 cycles.
    inst_addr1 = 32'h0000_0040; inst_req1 = 1'b1;
    acks = 0; last = 0; en1 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ram_en1) en1++;
      if (inst_ack1) begin
        if (acks == 0) chk32("l1_first_ack", i, 32'd2);
        else           chk32("l1_ack_spacing", i - last, 32'd3);
        chk32("l1_access_len", en1, 32'd1);
        exp1 = {22'd0, inst_addr1[11:2]} ^ 32'hA5A5_0000;
        chk32("l1_inst_data", inst_data1, exp1);
        chk1("l1_stall_at_ack", inst_stall1, 1'b0);
        en1 = 0; last = i; acks++;
        #1 inst_addr1 = inst_addr1 + 32'd4;
      end
    end
    chk32("l1_ack_count", acks, 32'd4);
    chk1("l1_no_write", ram_we1 | data_ack1 | data_stall1, 1'b0);
    chk32("l1_no_data", data_rdata1 | ram_wdata1, 32'd0);
    #1 inst_req1 = 1'b0;
    repeat (2) tick();

    // Random traffic checked by the per-cycle compare process.
    n_ia = 0; n_da = 0; irun = 0; drun = 0; imax = 0; dmax = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ia = inst_ack; da = data_ack;
      if (ia) n_ia++;
      if (da) n_da++;
      irun = inst_stall ? irun + 1 : 0;
      drun = data_stall ? drun + 1 : 0;
      if (irun > imax) imax = irun;
      if (drun > dmax) dmax = drun;
      #1;
      if (ia || !inst_req) begin
        inst_req = ($urandom_range(0, 3) != 0);
        if (inst_req) inst_addr = rand_addr();
      end else if (m_in_acc(1'b0)) begin
        inst_addr = $urandom;
      end
      if (da || !data_req) begin
        data_req = ($urandom_range(0, 3) != 0);
        if (data_req) begin
          data_addr  = rand_addr();
          data_wen   = 1'($urandom_range(0, 1));
          data_wdata = $urandom;
        end
      end else if (m_in_acc(1'b1)) begin
        data_addr  = $urandom;
        data_wen   = 1'($urandom_range(0, 1));
        data_wdata = $urandom;
      end
    end
    inst_req = 1'b0; data_req = 1'b0;
    repeat (8) tick();

    checks++;
    if (imax > 24) begin
      errors++;
      $display("FAIL rand_inst_max_stall actual=%0d required<=24", imax);
    end
    checks++;
    if (dmax > 12) begin
      errors++;
      $display("FAIL rand_data_max_stall actual=%0d required<=12", dmax);
    end
    checks++;
    if (n_ia < 50 || n_da < 50) begin
      errors++;
      $display("FAIL rand_ack_counts actual inst=%0d data=%0d required>=50 each", n_ia, n_da);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
